// File: rtl/reg_list_sequencer.sv
// Expands an LDM/STM/PUSH/POP register list into one load/store micro-op per
// listed register, in ascending register order, then strobes the base writeback.
module reg_list_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int LIST_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int SP_REG_NUM = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [1:0]            mode_i,
  input  logic [LIST_WIDTH-1:0] reg_list_i,
  input  logic [ADDR_WIDTH-1:0] base_reg_i,
  input  logic [DATA_WIDTH-1:0] base_val_i,
  input  logic                  flush_i,
  output logic                  uop_valid_o,
  input  logic                  uop_ready_i,
  output logic [ADDR_WIDTH-1:0] uop_reg_o,
  output logic [DATA_WIDTH-1:0] uop_addr_o,
  output logic                  uop_load_o,
  output logic                  uop_last_o,
  output logic                  wb_valid_o,
  output logic [ADDR_WIDTH-1:0] wb_reg_o,
  output logic [DATA_WIDTH-1:0] wb_val_o
);

  // Handshakes: a request moves on the edge where start_i && ready_o && !flush_i;
  // a micro-op moves on the edge where uop_valid_o && uop_ready_i, and uop_*
  // hold steady while uop_valid_o is high and uop_ready_i is low.

  localparam int CW = $clog2(LIST_WIDTH + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [LIST_WIDTH-1:0] rem_q;
  logic                  wb_en_q;
  logic [ADDR_WIDTH-1:0] wb_reg_q;
  logic [DATA_WIDTH-1:0] wb_val_q;

  logic [CW-1:0]         n_regs;
  logic [DATA_WIDTH-1:0] span;
  logic [LIST_WIDTH-1:0] rem_next;
  logic                  base_in_list;
  logic                  handshake;

  function automatic logic [ADDR_WIDTH-1:0] lowest(input logic [LIST_WIDTH-1:0] l);
    lowest = '0;
    for (int i = LIST_WIDTH - 1; i >= 0; i--)
      if (l[i]) lowest = ADDR_WIDTH'(i);
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [LIST_WIDTH-1:0] l);
    popcount = '0;
    for (int i = 0; i < LIST_WIDTH; i++)
      popcount = popcount + CW'(l[i]);
  endfunction

  function automatic logic one_left(input logic [LIST_WIDTH-1:0] l);
    one_left = (l != '0) && ((l & (l - LIST_WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    n_regs       = popcount(reg_list_i);
    span         = DATA_WIDTH'(n_regs) * DATA_WIDTH'(WORD_BYTES);
    rem_next     = rem_q & ~(LIST_WIDTH'(1) << uop_reg_o);
    base_in_list = |(reg_list_i & (LIST_WIDTH'(1) << base_reg_i));
    handshake    = uop_valid_o && uop_ready_i;
  end

  assign ready_o = (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      rem_q       <= '0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_val_q    <= '0;
      uop_valid_o <= 1'b0;
      uop_reg_o   <= '0;
      uop_addr_o  <= '0;
      uop_load_o  <= 1'b0;
      uop_last_o  <= 1'b0;
      wb_valid_o  <= 1'b0;
      wb_reg_o    <= '0;
      wb_val_o    <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (flush_i) begin
        state       <= IDLE;
        rem_q       <= '0;
        uop_valid_o <= 1'b0;
        uop_last_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // An empty list is accepted but leaves nothing to issue.
            if (start_i && reg_list_i != '0) begin
              state       <= ISSUE;
              rem_q       <= reg_list_i;
              uop_valid_o <= 1'b1;
              uop_reg_o   <= lowest(reg_list_i);
              uop_addr_o  <= (mode_i == 2'b10) ? base_val_i - span : base_val_i;
              uop_load_o  <= mode_i[0];
              uop_last_o  <= one_left(reg_list_i);
              wb_en_q     <= !(mode_i == 2'b01 && base_in_list);
              wb_reg_q    <= mode_i[1] ? ADDR_WIDTH'(SP_REG_NUM) : base_reg_i;
              wb_val_q    <= (mode_i == 2'b10) ? base_val_i - span : base_val_i + span;
            end
          end
          ISSUE: begin
            if (handshake) begin
              if (uop_last_o) begin
                state       <= IDLE;
                rem_q       <= '0;
                uop_valid_o <= 1'b0;
                uop_last_o  <= 1'b0;
                wb_valid_o  <= wb_en_q;
                wb_reg_o    <= wb_reg_q;
                wb_val_o    <= wb_val_q;
              end else begin
                rem_q      <= rem_next;
                uop_reg_o  <= lowest(rem_next);
                uop_addr_o <= uop_addr_o + DATA_WIDTH'(WORD_BYTES);
                uop_last_o <= one_left(rem_next);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer: directed list cases plus random
// requests, checked against a list-walking reference model.
module tb_reg_list_sequencer;

  localparam int AW = 4;
  localparam int LW = 16;
  localparam int DW = 32;
  localparam int WB = 4;
  localparam int SP = 13;
  localparam int UW = AW + DW + 2;
  localparam int WW = AW + DW;

  logic          clk, rst_n, start, flush, uop_ready;
  logic          ready, uop_valid, uop_load, uop_last, wb_valid;
  logic [1:0]    mode;
  logic [LW-1:0] reg_list;
  logic [AW-1:0] base_reg, uop_reg, wb_reg;
  logic [DW-1:0] base_val, uop_addr, wb_val;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  bit rand_ready = 0;
  logic ready_force = 1'b1;

  logic [UW-1:0] exp_q[$];
  logic [WW-1:0] exp_wb[$];

  reg_list_sequencer #(.ADDR_WIDTH(AW), .LIST_WIDTH(LW), .DATA_WIDTH(DW),
                       .WORD_BYTES(WB), .SP_REG_NUM(SP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .ready_o(ready),
    .mode_i(mode), .reg_list_i(reg_list), .base_reg_i(base_reg),
    .base_val_i(base_val), .flush_i(flush), .uop_valid_o(uop_valid),
    .uop_ready_i(uop_ready), .uop_reg_o(uop_reg), .uop_addr_o(uop_addr),
    .uop_load_o(uop_load), .uop_last_o(uop_last), .wb_valid_o(wb_valid),
    .wb_reg_o(wb_reg), .wb_val_o(wb_val)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // downstream ready: random or forced, applied 2 time units after each edge
  initial begin
    uop_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      uop_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // reference model: walk the list in ascending order
  task automatic model(input logic [1:0] m, input logic [LW-1:0] l,
                       input logic [AW-1:0] br, input logic [DW-1:0] bv);
    int n;
    int k;
    logic [DW-1:0] a;
    logic [DW-1:0] span;
    n = $countones(l);
    span = DW'(n * WB);
    a = (m == 2'b10) ? bv - span : bv;
    k = 0;
    for (int i = 0; i < LW; i++) begin
      if (l[i]) begin
        k++;
        exp_q.push_back({AW'(i), a, m[0], (k == n)});
        a = a + DW'(WB);
      end
    end
    if (n > 0 && !(m == 2'b01 && l[br]))
      exp_wb.push_back({(m[1] ? AW'(SP) : br), ((m == 2'b10) ? bv - span : bv + span)});
  endtask

  task automatic push_u(input int r, input logic [DW-1:0] a, input bit ld, input bit last);
    exp_q.push_back({AW'(r), a, ld, last});
  endtask

  task automatic push_w(input int r, input logic [DW-1:0] v);
    exp_wb.push_back({AW'(r), v});
  endtask

  // driver: call at posedge+1, returns at posedge+1 after the accepting edge
  task automatic issue(input logic [1:0] m, input logic [LW-1:0] l, input logic [AW-1:0] br,
                       input logic [DW-1:0] bv, input bit use_model);
    int guard;
    guard = 0;
    while (!ready && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0, required ready=1 within 2000 cycles");
      return;
    end
    mode = m;
    reg_list = l;
    base_reg = br;
    base_val = bv;
    start = 1'b1;
    if (use_model) model(m, l, br, bv);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (l != '0) begin
      check("accept_valid", 64'(uop_valid), 64'd1);
      check("accept_busy", 64'(ready), 64'd0);
    end else begin
      check("n0_ready", 64'(ready), 64'd1);
      check("n0_valid", 64'(uop_valid), 64'd0);
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && ready) && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 4000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d uops outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("wb_missing", 64'(exp_wb.size()), 64'd0);
    exp_wb.delete();
  endtask

  // monitor / scoreboard
  initial begin
    logic          prev_stall;
    logic [UW-1:0] held;
    logic [UW-1:0] got;
    logic [WW-1:0] got_wb;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        got = {uop_reg, uop_addr, uop_load, uop_last};
        if (prev_stall && uop_valid) check("hold", 64'(got), 64'(held));
        prev_stall = uop_valid && !uop_ready;
        held = got;
        if (uop_valid && uop_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) check("unexpected_uop", 64'(got), 64'd0);
          else check("uop", 64'(got), 64'(exp_q.pop_front()));
        end
        if (wb_valid) begin
          got_wb = {wb_reg, wb_val};
          if (exp_wb.size() == 0) check("unexpected_wb", 64'(got_wb), 64'd0);
          else check("wb", 64'(got_wb), 64'(exp_wb.pop_front()));
        end
      end
    end
  end

  // stimulus
  initial begin
    int hs_base;
    int guard;
    int sel;
    logic [1:0]    m;
    logic [LW-1:0] l;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    mode = '0; reg_list = '0; base_reg = '0; base_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(uop_valid), 64'd0);
    check("rst_last", 64'(uop_last), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_data", 64'({uop_reg, uop_addr, uop_load, wb_reg, wb_val}), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // PUSH
    ready_force = 1'b1;
    push_u(0, 32'h0FF4, 0, 0); push_u(4, 32'h0FF8, 0, 0); push_u(14, 32'h0FFC, 0, 1);
    push_w(SP, 32'h0FF4);
    issue(2'b10, 16'h4011, 4'd7, 32'h1000, 0);
    wait_done();

    // LDM with base in list: no writeback
    push_u(1, 32'h2000, 1, 0); push_u(2, 32'h2004, 1, 1);
    issue(2'b01, 16'h0006, 4'd2, 32'h2000, 0);
    wait_done();

    // STM with a 3-cycle stall on the first uop
    ready_force = 1'b0;
    push_u(0, 32'h3000, 0, 0); push_u(7, 32'h3004, 0, 1);
    push_w(3, 32'h3008);
    issue(2'b00, 16'h0081, 4'd3, 32'h3000, 0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_reg", 64'({uop_valid, uop_reg, uop_addr}), 64'({1'b1, 4'd0, 32'h3000}));
    ready_force = 1'b1;
    wait_done();

    // POP wrapping past zero
    push_u(0, 32'hFFFF_FFFC, 1, 0); push_u(15, 32'h0000_0000, 1, 1);
    push_w(SP, 32'h0000_0004);
    issue(2'b11, 16'h8001, 4'd0, 32'hFFFF_FFFC, 0);
    wait_done();

    // flush after the second handshake
    push_u(0, 32'h5000, 0, 0); push_u(1, 32'h5004, 0, 0);
    hs_base = hs_cnt;
    issue(2'b00, 16'h00FF, 4'd5, 32'h5000, 0);
    guard = 0;
    while (hs_cnt < hs_base + 2 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("flush_hs", 64'(hs_cnt - hs_base), 64'd2);
    flush = 1'b1;
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    ready_force = 1'b1;
    check("flush_ready", 64'(ready), 64'd1);
    check("flush_valid", 64'(uop_valid), 64'd0);
    wait_done();

    // empty list: never busy
    issue(2'b00, 16'h0000, 4'd3, 32'h0100, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("n0_hold_ready", 64'(ready), 64'd1);
    end

    // flush beats a same-cycle start
    mode = 2'b00; reg_list = 16'h0003; base_reg = 4'd1; base_val = 32'h40;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_valid", 64'(uop_valid), 64'd0);
    check("flush_start_ready", 64'(ready), 64'd1);

    // reset mid-sequence
    issue(2'b00, 16'h00FF, 4'd1, 32'h0100, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(uop_valid), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_wb", 64'(wb_valid), 64'd0);
    exp_q.delete();
    exp_wb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_idle", 64'({ready, uop_valid}), 64'({1'b1, 1'b0}));

    // random back-to-back requests with random downstream ready
    rand_ready = 1;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 7);
      m = 2'($urandom_range(0, 3));
      l = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      issue(m, l, 4'($urandom_range(0, 15)),
            (sel == 2) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom, 1);
    end
    wait_done();
    rand_ready = 0;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
